imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/imem_loader_if.sv | 37 +++
 rtl/imem_word_packer.sv | 46 ++++
 rtl/imem_loader.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the byte geometry of one instruction word.
package riscv_pkg;

    // Bytes that make up one instruction word on the serial stream.
    localparam int BYTES_PER_WORD = 4;

    // Width of the byte-lane index within a word.
    localparam int BYTE_IDX_W = $clog2(BYTES_PER_WORD);

    // Width of the length field carried in the two length bytes.
    localparam int LEN_WIDTH = 16;

    // Loader FSM states, in stream order.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } loader_state_t;

    // States in which a fresh start pulse is honoured.
    function automatic logic start_allowed(input loader_state_t s);
        return (s == IDLE) || (s == DONE) || (s == ERR);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake plus IMem write port, bundled so the loader
// and its surroundings connect through a single port.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
);
    // Serial byte source.
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;

    // IMem write port.
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [INST_WIDTH-1:0] wdata;

    // Loader side: consumes bytes, drives the IMem write port.
    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output we,
        output waddr,
        output wdata
    );

    // Environment side: supplies bytes, observes the IMem write port.
    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  we,
        input  waddr,
        input  wdata
    );

endinterface

// File: rtl/imem_word_packer.sv
// Assembles little-endian instruction words from accepted bytes and keeps a
// running XOR checksum of every byte it sees.
module imem_word_packer
    import riscv_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,      // restart: new load begins
    input  logic                        byte_valid, // a data byte is accepted this cycle
    input  logic [7:0]                  byte_data,
    output logic                        last_byte,  // the current byte completes a word
    output logic [BYTES_PER_WORD*8-1:0] word,       // word completed by the current byte
    output logic [7:0]                  csum        // XOR of all bytes accepted so far
);

    localparam int LOW_W = (BYTES_PER_WORD - 1) * 8;

    logic [BYTE_IDX_W-1:0] byte_idx;
    logic [LOW_W-1:0]      low_bytes;

    // The final byte is combined directly so the word is ready in the same
    // cycle as its last handshake; the loader registers it on that edge.
    assign last_byte = (byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));
    assign word      = {byte_data, low_bytes};

    // Shift bytes in from the top so the first byte ends up least significant.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            byte_idx  <= '0;
            low_bytes <= '0;
            csum      <= '0;
        end else if (clear) begin
            byte_idx  <= '0;
            low_bytes <= '0;
            csum      <= '0;
        end else if (byte_valid) begin
            // Index wraps naturally after the last byte of a word.
            byte_idx  <= byte_idx + 1'b1;
            low_bytes <= {byte_data, low_bytes[LOW_W-1:8]};
            csum      <= csum ^ byte_data;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Receives a length-prefixed, checksummed byte stream and writes the carried
// instruction words into IMem, holding the CPU until a load succeeds.
module imem_loader
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int IMEM_DEPTH = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    imem_loader_if.master        bus,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [LEN_WIDTH-1:0] word_count
);

    // Largest word count that fits the IMem.
    localparam int unsigned MAX_WORDS = IMEM_DEPTH / BYTES_PER_WORD;

    loader_state_t               state;
    logic [7:0]                  len_lo;
    logic [LEN_WIDTH-1:0]        len;

    logic                        xfer;
    logic                        start_ok;
    logic                        data_xfer;
    logic [LEN_WIDTH-1:0]        len_rx;
    logic [LEN_WIDTH-1:0]        wc_next;

    logic                        pk_last;
    logic [BYTES_PER_WORD*8-1:0] pk_word;
    logic [7:0]                  pk_csum;

    assign xfer      = bus.rx_valid && bus.rx_ready;
    assign start_ok  = start && start_allowed(state);
    assign data_xfer = xfer && (state == DATA);
    assign len_rx    = {bus.rx_data, len_lo};
    assign wc_next   = word_count + 1'b1;

    imem_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok),
        .byte_valid (data_xfer),
        .byte_data  (bus.rx_data),
        .last_byte  (pk_last),
        .word       (pk_word),
        .csum       (pk_csum)
    );

    // Loader FSM: every output is registered and updated on the transition
    // that enters the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            len_lo       <= '0;
            len          <= '0;
            bus.rx_ready <= 1'b0;
            bus.we       <= 1'b0;
            bus.waddr    <= '0;
            bus.wdata    <= '0;
            cpu_hold     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            word_count   <= '0;
        end else begin
            // Write strobe is a single-cycle pulse unless a word completes.
            bus.we <= 1'b0;

            case (state)
                IDLE, DONE, ERR: begin
                    // rx_ready is low here, so a coincident byte is never taken.
                    if (start) begin
                        state        <= LEN_LO;
                        bus.rx_ready <= 1'b1;
                        busy         <= 1'b1;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        word_count   <= '0;
                    end
                end

                LEN_LO: begin
                    if (xfer) begin
                        len_lo <= bus.rx_data;
                        state  <= LEN_HI;
                    end
                end

                LEN_HI: begin
                    if (xfer) begin
                        len <= len_rx;
                        if (32'(len_rx) > MAX_WORDS) begin
                            // Oversized image: reject before touching IMem.
                            state        <= ERR;
                            bus.rx_ready <= 1'b0;
                            busy         <= 1'b0;
                            error        <= 1'b1;
                        end else if (len_rx == '0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (xfer && pk_last) begin
                        bus.we     <= 1'b1;
                        bus.waddr  <= ADDR_WIDTH'(int'(word_count) * BYTES_PER_WORD);
                        bus.wdata  <= INST_WIDTH'(pk_word);
                        word_count <= wc_next;
                        if (wc_next == len) begin
                            state <= CSUM;
                        end
                    end
                end

                CSUM: begin
                    if (xfer) begin
                        bus.rx_ready <= 1'b0;
                        busy         <= 1'b0;
                        if (bus.rx_data == pk_csum) begin
                            // Only a verified image releases the CPU.
                            state    <= DONE;
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end

                default: begin
                    state        <= IDLE;
                    bus.rx_ready <= 1'b0;
                    busy         <= 1'b0;
                    cpu_hold     <= 1'b1;
                end
            endcase
        end
    end

endmodule
